// File: rtl/sprite_line_fetcher_pkg.sv
// Shared definitions for the sprite line fetch path: default geometry,
// address packing width and the fetch FSM state encoding.
package sprite_line_fetcher_pkg;

  localparam int unsigned SPRITE_BITS_DEF = 6;
  localparam int unsigned ROW_BITS_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  // Bit address is packed {sprite, row, col}; row and col share ROW_BITS.
  function automatic int unsigned addr_width(input int unsigned sprite_bits,
                                             input int unsigned row_bits);
    return sprite_bits + 2 * row_bits;
  endfunction

endpackage

// File: rtl/sprite_line_fetcher.sv
// Fetches one row of a 1bpp sprite with serial single-bit reads and presents
// the assembled line word to the renderer over a valid/ready handshake.
module sprite_line_fetcher
  import sprite_line_fetcher_pkg::*;
#(
  parameter int unsigned SPRITE_BITS = SPRITE_BITS_DEF,
  parameter int unsigned ROW_BITS    = ROW_BITS_DEF,
  localparam int unsigned W = 2 ** ROW_BITS,
  localparam int unsigned A = addr_width(SPRITE_BITS, ROW_BITS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SPRITE_BITS-1:0] req_sprite,
  input  logic [ROW_BITS-1:0]    req_row,
  input  logic                   req_flip_x,
  output logic                   mem_ren,
  output logic [A-1:0]           mem_raddr,
  input  logic                   mem_rdata,
  output logic                   line_valid,
  input  logic                   line_ready,
  output logic [W-1:0]           line_data,
  output logic                   line_nonzero
);

  fetch_state_e           state;
  logic [SPRITE_BITS-1:0] sprite_q;
  logic [ROW_BITS-1:0]    row_q;
  logic                   flip_q;
  logic [ROW_BITS-1:0]    col;
  logic [ROW_BITS-1:0]    col_inc;
  logic [ROW_BITS-1:0]    col_d;
  logic                   cap;
  logic [ROW_BITS-1:0]    ins_pos;
  logic [W-1:0]           line_next;

  assign req_ready = (state == ST_IDLE) && !reset;
  assign col_inc   = col + 1'b1;

  // col_d/cap trail the issued read by one cycle so they line up with rdata.
  // Unflipped, col k lands at bit W-1-k, which is ~k for a power-of-two width.
  always_comb begin
    ins_pos            = flip_q ? col_d : ~col_d;
    line_next          = line_data;
    line_next[ins_pos] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      sprite_q     <= '0;
      row_q        <= '0;
      flip_q       <= 1'b0;
      col          <= '0;
      col_d        <= '0;
      cap          <= 1'b0;
      mem_ren      <= 1'b0;
      mem_raddr    <= '0;
      line_valid   <= 1'b0;
      line_data    <= '0;
      line_nonzero <= 1'b0;
    end else begin
      cap   <= mem_ren;
      col_d <= col;
      if (cap) begin
        line_data    <= line_next;
        line_nonzero <= |line_next;
      end

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            sprite_q  <= req_sprite;
            row_q     <= req_row;
            flip_q    <= req_flip_x;
            col       <= '0;
            mem_ren   <= 1'b1;
            mem_raddr <= {req_sprite, req_row, {ROW_BITS{1'b0}}};
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (col == '1) begin
            mem_ren <= 1'b0;
            state   <= ST_DRAIN;
          end else begin
            col       <= col_inc;
            mem_raddr <= {sprite_q, row_q, col_inc};
          end
        end
        ST_DRAIN: begin
          line_valid <= 1'b1;
          state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (line_ready) begin
            line_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Scoreboard bench for sprite_line_fetcher against a behavioural sprite memory
// and a reference that reads rows straight out of that memory.
module tb_sprite_line_fetcher;

  localparam int SB = 6;
  localparam int RB = 4;
  localparam int W  = 16;
  localparam int A  = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [SB-1:0] req_sprite;
  logic [RB-1:0] req_row;
  logic          req_flip_x;
  logic          mem_ren;
  logic [A-1:0]  mem_raddr;
  logic          mem_rdata = 1'b0;
  logic          line_valid;
  logic          line_ready = 1'b0;
  logic [W-1:0]  line_data;
  logic          line_nonzero;

  logic mem [0:(1<<A)-1];

  typedef struct {
    logic [W-1:0] data;
    logic         nz;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned addr_q[$];
  int unsigned cyc = 0;
  int unsigned accept_cyc = 0;
  int          lr_mode = 0;
  int          total = 0;
  int          bad = 0;

  sprite_line_fetcher #(.SPRITE_BITS(SB), .ROW_BITS(RB)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sprite   (req_sprite),
    .req_row      (req_row),
    .req_flip_x   (req_flip_x),
    .mem_ren      (mem_ren),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .line_data    (line_data),
    .line_nonzero (line_nonzero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // One-cycle-latency memory; junk on idle cycles exposes mistimed captures.
  always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_raddr] : 1'($urandom);

  always @(posedge clk) begin
    #1;
    case (lr_mode)
      0:       line_ready = 1'b1;
      1:       line_ready = 1'($urandom);
      default: line_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none t=%0t", name, $time);
  endtask

  // Row k of a sprite is pixel columns 0..W-1; leftmost pixel goes to the MSB
  // unless mirrored.
  function automatic logic [W-1:0] ref_line(input int s, input int r, input bit f);
    logic [W-1:0] v;
    for (int k = 0; k < W; k++) begin
      if (f) v[k]       = mem[s*W*W + r*W + k];
      else   v[W-1-k]   = mem[s*W*W + r*W + k];
    end
    return v;
  endfunction

  bit           prev_lv = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_nz;

  always @(negedge clk) begin
    exp_t        e;
    int unsigned ea;
    if (mem_ren === 1'b1) begin
      if (addr_q.size() == 0) fail("unexpected_read");
      else begin
        ea = addr_q.pop_front();
        chk("mem_raddr", 32'(mem_raddr), ea);
      end
    end
    if (line_valid === 1'b1) begin
      if (!prev_lv) chk("line_latency", cyc - accept_cyc, 18);
      else begin
        chk("hold_data", 32'(line_data), 32'(prev_data));
        chk("hold_nonzero", 32'(line_nonzero), 32'(prev_nz));
      end
      chk("hold_mem_ren", 32'(mem_ren), 0);
      chk("hold_req_ready", 32'(req_ready), 0);
      if (line_ready === 1'b1) begin
        if (exp_q.size() == 0) fail("unexpected_line");
        else begin
          e = exp_q.pop_front();
          chk("line_data", 32'(line_data), 32'(e.data));
          chk("line_nonzero", 32'(line_nonzero), 32'(e.nz));
        end
      end
    end
    prev_lv   = (line_valid === 1'b1);
    prev_data = line_data;
    prev_nz   = line_nonzero;
    if (reset === 1'b1) begin
      addr_q.delete();
      exp_q.delete();
    end else if (req_valid === 1'b1 && req_ready === 1'b1) begin
      accept_cyc = cyc;
      for (int k = 0; k < W; k++)
        addr_q.push_back(int'(req_sprite)*W*W + int'(req_row)*W + k);
      e.data = ref_line(int'(req_sprite), int'(req_row), req_flip_x);
      e.nz   = (e.data != 0);
      exp_q.push_back(e);
    end
  end

  task automatic do_req(input int s, input int r, input bit f, input bit toggle);
    bit got = 1'b0;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_sprite = SB'(s);
    req_row    = RB'(r);
    req_flip_x = f;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) got = 1'b1;
    end
    if (!got) fail("req_accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (toggle) begin
      for (int i = 0; i < W; i++) begin
        req_sprite = SB'($urandom);
        req_row    = RB'($urandom);
        req_flip_x = 1'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_ready === 1'b1) done = 1'b1;
    end
    if (!done) fail("idle_timeout");
  endtask

  initial begin
    logic [W-1:0] pat;
    bit           seen;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_sprite = '0;
    req_row    = '0;
    req_flip_x = 1'b0;

    for (int i = 0; i < (1 << A); i++) mem[i] = 1'($urandom);
    pat = 16'hA5C3;
    for (int k = 0; k < W; k++) begin
      mem[5*W*W + 3*W + k]   = pat[W-1-k];
      mem[63*W*W + 15*W + k] = 1'b1;
      mem[10*W*W + 0*W + k]  = 1'b0;
    end

    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_mem_ren", 32'(mem_ren), 0);
    chk("reset_mem_raddr", 32'(mem_raddr), 0);
    chk("reset_line_valid", 32'(line_valid), 0);
    chk("reset_line_data", 32'(line_data), 0);
    chk("reset_line_nonzero", 32'(line_nonzero), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 1);

    do_req(5, 3, 1'b0, 1'b0);   wait_idle();
    do_req(5, 3, 1'b1, 1'b0);   wait_idle();
    do_req(63, 15, 1'b0, 1'b0); wait_idle();
    do_req(10, 0, 1'b0, 1'b0);  wait_idle();

    // Renderer stalls; a second request queues behind the held line.
    lr_mode = 2;
    do_req(7, 2, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (line_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) fail("hold_line_timeout");
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_sprite = 6'd44;
    req_row    = 4'd6;
    req_flip_x = 1'b1;
    @(negedge clk);
    lr_mode = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (line_valid === 1'b1 && line_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) fail("handshake_timeout");
    @(negedge clk);
    chk("b2b_req_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_fetching", 32'(mem_ren), 1);
    wait_idle();

    // Reset lands while col 7 is being read.
    do_req(20, 9, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (mem_ren === 1'b1 && mem_raddr[3:0] == 4'd7) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) fail("col7_timeout");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_mem_ren", 32'(mem_ren), 0);
    chk("rst_mid_line_valid", 32'(line_valid), 0);
    do_req(20, 9, 1'b1, 1'b0);  wait_idle();

    do_req(33, 12, 1'b0, 1'b1); wait_idle();
    do_req(61, 1, 1'b1, 1'b1);  wait_idle();

    lr_mode = 1;
    for (int n = 0; n < 40; n++)
      do_req(int'($urandom_range(63)), int'($urandom_range(15)), 1'($urandom), 1'($urandom));
    lr_mode = 0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
